// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program RAM port, decode handshake and execute redirect.
// Revision: 1.0
`default_nettype none

interface instr_fetch_if;
  logic        mode;
  logic [15:0] instr_in;
  logic [7:0]  addrPC;
  logic [15:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        halted;

  modport master (
    input  mode, instr_in, instr_ready, branch_valid, branch_target,
    output addrPC, instr_out, pc_out, instr_valid, halted
  );

  modport slave (
    output mode, instr_in, instr_ready, branch_valid, branch_target,
    input  addrPC, instr_out, pc_out, instr_valid, halted
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetcher with decode backpressure, branch redirect and halt.
// Revision: 1.0
`default_nettype none

module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_out_q, instr_out_d;
  logic [7:0]  pc_out_q, pc_out_d;
  logic        instr_valid_q, instr_valid_d;
  logic        mode_prev_q, mode_prev_d;

  logic run_entry;
  logic adv;

  assign run_entry = bus.mode & ~mode_prev_q;
  assign adv       = (state_q == FETCH) & (~instr_valid_q | bus.instr_ready) & ~bus.branch_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    mode_prev_d   = bus.mode;

    // Leaving run mode overrides every other event.
    if (!bus.mode) begin
      state_d       = IDLE;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_entry) begin
            state_d = FETCH;
            pc_d    = RESET_PC;
          end
        end
        FETCH: begin
          if (bus.branch_valid) begin
            pc_d          = bus.branch_target;
            instr_valid_d = 1'b0;
          end else if (adv) begin
            instr_out_d   = bus.instr_in;
            pc_out_d      = pc_q;
            instr_valid_d = 1'b1;
            if (bus.instr_in[15:12] == HALT_OP) begin
              state_d = HALT;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
        end
        HALT: begin
          if (bus.instr_ready) begin
            instr_valid_d = 1'b0;
          end
        end
        default: begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_out_q   <= 16'd0;
      pc_out_q      <= 8'd0;
      instr_valid_q <= 1'b0;
      mode_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      mode_prev_q   <= mode_prev_d;
    end
  end

  assign bus.addrPC      = pc_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = (state_q == HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic against a cycle-level reference model.
// Revision: 1.0
`default_nettype none

module tb_instr_fetch;

  localparam logic [7:0] RESET_PC = 8'd0;
  localparam logic [3:0] HALT_OP  = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .HALT_OP  (HALT_OP)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [256];
  assign bus.instr_in = ram[bus.addrPC];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "fetching" / "stopped at halt" flags plus the presented word.
  logic        m_fetching, m_halted, m_valid, m_mode_prev;
  logic [7:0]  m_pc, m_out_pc;
  logic [15:0] m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetching  = 1'b0;
    m_halted    = 1'b0;
    m_valid     = 1'b0;
    m_mode_prev = 1'b0;
    m_pc        = RESET_PC;
    m_out_pc    = 8'd0;
    m_out       = 16'd0;
  endtask

  task automatic model_step();
    logic [15:0] word;
    if (!bus.mode) begin
      m_fetching = 1'b0;
      m_halted   = 1'b0;
      m_valid    = 1'b0;
    end else if (!m_mode_prev) begin
      m_fetching = 1'b1;
      m_halted   = 1'b0;
      m_pc       = RESET_PC;
    end else if (m_halted) begin
      if (bus.instr_ready) m_valid = 1'b0;
    end else if (m_fetching) begin
      if (bus.branch_valid) begin
        m_pc    = bus.branch_target;
        m_valid = 1'b0;
      end else if (!m_valid || bus.instr_ready) begin
        word     = ram[m_pc];
        m_out    = word;
        m_out_pc = m_pc;
        m_valid  = 1'b1;
        if (word[15:12] == HALT_OP) begin
          m_halted   = 1'b1;
          m_fetching = 1'b0;
        end else begin
          m_pc = 8'(m_pc + 1);
        end
      end
    end
    m_mode_prev = bus.mode;
  endtask

  task automatic compare_all();
    chk("addrPC", bus.addrPC, m_pc);
    chk("instr_valid", bus.instr_valid, m_valid);
    chk("halted", bus.halted, m_halted);
    chk("instr_out", bus.instr_out, m_out);
    chk("pc_out", bus.pc_out, m_out_pc);
  endtask

  // Inputs are set at the falling edge; model advances on the rising edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addrPC"}, bus.addrPC, RESET_PC);
    chk({tag, "_valid"}, bus.instr_valid, 1'b0);
    chk({tag, "_halted"}, bus.halted, 1'b0);
    chk({tag, "_instr_out"}, bus.instr_out, 16'd0);
    chk({tag, "_pc_out"}, bus.pc_out, 8'd0);
  endtask

  // Reset pulse wholly between two rising edges; outputs must clear before the next edge.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {4'h1, 4'h0, 8'(i)};
    ram[0] = 16'h1234;
    ram[1] = 16'h2345;
    ram[2] = 16'h3456;
    bus.mode          = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    cyc();

    // Run entry and first three fetches.
    bus.mode = 1'b1;
    cyc();
    chk("entry_valid_low", bus.instr_valid, 1'b0);
    cyc();
    chk("first_valid", bus.instr_valid, 1'b1);
    chk("first_pc", bus.pc_out, 8'd0);
    chk("first_instr", bus.instr_out, 16'h1234);
    cyc();
    chk("second_instr", bus.instr_out, 16'h2345);
    cyc();
    chk("third_pc", bus.pc_out, 8'd2);
    chk("third_instr", bus.instr_out, 16'h3456);

    // Decode stall for three cycles.
    bus.instr_ready = 1'b0;
    repeat (3) cyc();
    chk("stall_pc_out", bus.pc_out, 8'd2);
    chk("stall_addr", bus.addrPC, 8'd3);
    bus.instr_ready = 1'b1;
    cyc();
    chk("post_stall_pc", bus.pc_out, 8'd3);

    // Redirect while word at 5 is valid and not accepted.
    for (int k = 0; k < 20 && !(m_valid && m_out_pc == 8'd5); k++) cyc();
    chk("pre_branch_pc", bus.pc_out, 8'd5);
    bus.instr_ready   = 1'b0;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h40;
    cyc();
    chk("branch_squash", bus.instr_valid, 1'b0);
    bus.branch_valid = 1'b0;
    bus.instr_ready  = 1'b1;
    cyc();
    chk("branch_target_pc", bus.pc_out, 8'h40);

    // Halt opcode at address 3.
    bus.mode = 1'b0;
    cyc();
    ram[3] = 16'hF000;
    bus.mode = 1'b1;
    repeat (8) cyc();
    chk("halt_flag", bus.halted, 1'b1);
    chk("halt_addr", bus.addrPC, 8'd3);
    chk("halt_pc_out", bus.pc_out, 8'd3);
    chk("halt_valid_drop", bus.instr_valid, 1'b0);
    bus.mode = 1'b0;
    cyc();
    bus.mode = 1'b1;
    cyc();
    cyc();
    chk("restart_pc", bus.pc_out, 8'd0);
    ram[3] = 16'h1003;

    // 257 accepts across the address wrap.
    bus.mode = 1'b0;
    cyc();
    bus.mode = 1'b1;
    cyc();
    repeat (256) cyc();
    chk("wrap_last", bus.pc_out, 8'd255);
    cyc();
    chk("wrap_zero", bus.pc_out, 8'd0);

    // Asynchronous reset mid-fetch; mode still high counts as a fresh entry.
    async_reset_pulse();
    cyc();
    chk("rst_reentry_valid", bus.instr_valid, 1'b0);
    cyc();
    chk("rst_reentry_pc", bus.pc_out, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      if (ram[i][15:12] == HALT_OP && ($urandom % 3 != 0)) ram[i][15:12] = 4'h2;
    end
    for (int n = 0; n < 3000; n++) begin
      bus.mode          = ($urandom % 40) != 0;
      bus.instr_ready   = ($urandom % 4) != 0;
      bus.branch_valid  = ($urandom % 12) == 0;
      bus.branch_target = 8'($urandom);
      if (($urandom % 300) == 0) async_reset_pulse();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
